// File: rtl/mxrv_div_pkg.sv
// Shared funct3 codes, FSM state encoding and opcode helpers for the RV32M
// divide sequencer.
package mxrv_div_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } div_state_t;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == INST_REM) || (f3 == INST_REMU);
  endfunction

endpackage

// File: rtl/mxrv_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract the
// divisor from the partial remainder and keep the difference if it fits.
module mxrv_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] trial;
  logic              unused_trial_msb;

  // The extra top bit of trial is the borrow; a clear borrow means rem_sh >= divisor.
  always_comb begin
    rem_sh = {rem, quo[DATA_W-1]};
    trial  = {1'b0, rem_sh} - {2'b00, divisor};
    if (!trial[DATA_W+1]) begin
      rem_next = trial[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

  assign unused_trial_msb = trial[DATA_W];

endmodule

// File: rtl/mxrv_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: special cases resolve in START, everything
// else runs 32 restoring steps in CALC before a one-cycle result in END.
module mxrv_div_ctrl
  import mxrv_div_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  cancel_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  rd_wr_en_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              funct3_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]       dividend_q;
  logic [DATA_W-1:0]       divisor_q;
  logic [DATA_W-1:0]       rem_q;
  logic [DATA_W-1:0]       quo_q;
  logic [DATA_W-1:0]       dvs_q;
  logic                    q_neg;
  logic                    r_neg;
  logic                    busy_q;
  logic                    ready_q;
  logic [DATA_W-1:0]       result_q;
  logic [REG_ADDR_W-1:0]   rd_out_q;

  logic [DATA_W-1:0]       rem_next;
  logic [DATA_W-1:0]       quo_next;
  logic                    is_signed;
  logic                    is_rem;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_W-1:0]       quo_fixed;
  logic [DATA_W-1:0]       rem_fixed;

  mxrv_div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    is_signed = f3_is_signed(funct3_q);
    is_rem    = f3_is_rem(funct3_q);
    a_neg     = is_signed & dividend_q[DATA_W-1];
    b_neg     = is_signed & divisor_q[DATA_W-1];
    quo_fixed = q_neg ? -quo_next : quo_next;
    rem_fixed = r_neg ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start_i && !cancel_i) begin
            funct3_q   <= funct3_i;
            rd_q       <= rd_i;
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            busy_q     <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          if (cancel_i) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (divisor_q == '0) begin
            result_q <= is_rem ? dividend_q : '1;
            rd_out_q <= rd_q;
            ready_q  <= 1'b1;
            state    <= S_END;
          end else if (is_signed && dividend_q == MIN_NEG && divisor_q == '1) begin
            result_q <= is_rem ? '0 : MIN_NEG;
            rd_out_q <= rd_q;
            ready_q  <= 1'b1;
            state    <= S_END;
          end else begin
            rem_q <= '0;
            quo_q <= a_neg ? -dividend_q : dividend_q;
            dvs_q <= b_neg ? -divisor_q : divisor_q;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (cancel_i) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + CNT_W'(1);
            // Last step: the sign fix is taken straight from this step's outputs.
            if (cnt == CNT_W'(DATA_W - 1)) begin
              result_q <= is_rem ? rem_fixed : quo_fixed;
              rd_out_q <= rd_q;
              ready_q  <= 1'b1;
              state    <= S_END;
            end
          end
        end
        S_END: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // A flush arriving in the END cycle still has to suppress the write.
  assign ready_o    = ready_q & ~cancel_i;
  assign rd_wr_en_o = ready_q & ~cancel_i;
  assign busy_o     = busy_q;
  assign result_o   = result_q;
  assign rd_o       = rd_out_q;

endmodule

// File: tb/tb_mxrv_div_ctrl.sv
// Self-checking bench for mxrv_div_ctrl: arithmetic reference model checked
// every cycle, plus directed operations with hand-computed results and latencies.
module tb_mxrv_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] dividend_i = 32'h0;
  logic [31:0] divisor_i = 32'h0;
  logic [4:0]  rd_i = 5'h0;
  logic        cancel_i = 1'b0;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        rd_wr_en_o;

  mxrv_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_i       (rd_i),
    .cancel_i   (cancel_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .rd_o       (rd_o),
    .rd_wr_en_o (rd_wr_en_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f)
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
    sgn = (f == 3'b100) || (f == 3'b110);
    if (b == 0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Model: at most one operation in flight, identified by accept and ready cycles.
  bit          pend = 1'b0;
  int          acc_cyc = 0;
  int          rdy_cyc = 0;
  logic [31:0] m_res = 32'h0;
  logic [4:0]  m_rd = 5'h0;

  always @(negedge clk) begin
    bit exp_ready;
    bit exp_busy;
    exp_ready = pend && (cyc == rdy_cyc) && !cancel_i && !rst;
    exp_busy  = pend && (cyc > acc_cyc) && !rst;
    check("ready", {31'h0, ready_o}, {31'h0, exp_ready});
    check("rd_wr_en", {31'h0, rd_wr_en_o}, {31'h0, exp_ready});
    check("busy", {31'h0, busy_o}, {31'h0, exp_busy});
    if (exp_ready) begin
      check("model_result", result_o, m_res);
      check("model_rd", {27'h0, rd_o}, {27'h0, m_rd});
    end
    if (rst) begin
      check("rst_result", result_o, 32'h0);
      check("rst_rd", {27'h0, rd_o}, 32'h0);
      pend = 1'b0;
    end else if (pend && (cyc > acc_cyc) && (cancel_i || cyc == rdy_cyc)) begin
      pend = 1'b0;
    end else if (!pend && start_i && !cancel_i) begin
      pend    = 1'b1;
      acc_cyc = cyc;
      rdy_cyc = cyc + ref_latency(funct3_i, dividend_i, divisor_i);
      m_res   = ref_result(funct3_i, dividend_i, divisor_i);
      m_rd    = rd_i;
    end
  end

  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    start_i    = 1'b1;
    funct3_i   = f;
    dividend_i = a;
    divisor_i  = b;
    rd_i       = rd;
  endtask

  // Issues one op in the next cycle and checks the literal result and latency.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int t0;
    bit got;
    @(posedge clk);
    #1;
    cancel_i = 1'b0;
    drive_start(f, a, b, rd);
    t0 = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        check({name, "_result"}, result_o, exp_res);
        check({name, "_rd"}, {27'h0, rd_o}, {27'h0, rd});
        check({name, "_latency"}, cyc - t0, exp_lat);
      end
    end
    if (!got) check({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_ready", {31'h0, ready_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34);
    run_op("remu_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, 34);
    run_op("div_by0", 3'b100, 32'd123, 32'd0, 5'd4, 32'hFFFF_FFFF, 2);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd6, 32'd5, 2);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 2);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0, 2);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'hFFFF_FFFF, 34);
    run_op("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1, 34);
    run_op("remu_3_max", 3'b111, 32'd3, 32'hFFFF_FFFF, 5'd12, 32'd3, 34);
    run_op("div_minneg_2", 3'b100, 32'h8000_0000, 32'd2, 5'd13, 32'hC000_0000, 34);
    run_op("divu_0_5", 3'b101, 32'd0, 32'd5, 5'd31, 32'd0, 34);

    // start and cancel together in IDLE: nothing may be accepted
    @(posedge clk);
    #1;
    drive_start(3'b101, 32'd50, 32'd5, 5'd14);
    cancel_i = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    idle_cycles(4);

    // cancel mid-CALC at T+10, ignored start at T+5, fresh start at T+11
    @(posedge clk);
    #1;
    drive_start(3'b101, 32'd1000, 32'd3, 5'd15);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      start_i  = 1'b0;
      cancel_i = (k == 10);
      if (k == 5) drive_start(3'b100, 32'd77, 32'd0, 5'd16);
    end
    run_op("after_cancel", 3'b111, 32'd1000, 32'd7, 5'd17, 32'd6, 34);

    // reset pulse at T+20 of a running op
    @(posedge clk);
    #1;
    drive_start(3'b101, 32'hDEAD_BEEF, 32'd7, 5'd18);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'h0, busy_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(40);
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd19, 32'd3, 34);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
